// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: shared M-extension encodings, FSM states, default width.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mdu_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mdu_step: one radix-2 shift-add (mul) or restoring (div) step.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_mdu_step
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  step_mode_t      mode,
  input  logic [XLEN-1:0] acc_in,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] sreg_in,
  output logic [XLEN-1:0] acc_out,
  output logic [XLEN-1:0] sreg_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc_in} + (sreg_in[0] ? {1'b0, opnd} : '0);
    shifted  = {acc_in, sreg_in[XLEN-1]};
    diff     = shifted - {1'b0, opnd};
    acc_out  = sum[XLEN:1];
    sreg_out = {sum[0], sreg_in[XLEN-1:1]};
    if (mode == STEP_DIV) begin
      // The partial remainder stays below the divisor, so a clear MSB means no borrow.
      if (!diff[XLEN]) begin
        acc_out  = diff[XLEN-1:0];
        sreg_out = {sreg_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out  = shifted[XLEN-1:0];
        sreg_out = {sreg_in[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mdu_seq: iterative RV32M multiply/divide, START/BUSY/VALID.       |
// | ALU_MDU_FAST_MUL_EN: single registered multiply for MUL* ops. Rev 1.0 |
// +----------------------------------------------------------------------+
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic [XLEN-1:0]   acc, sreg, opnd;
  logic [CNT_W-1:0]  cnt;
  logic              neg_lo, neg_hi;

  logic              in_neg_a, in_neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, fast_val;
  logic              div_zero, div_ovf, fast_div, accept;

  logic [XLEN-1:0]   step_acc, step_sreg;
  step_mode_t        step_mode;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  assign in_neg_a = signed_a(SELECT) & DATA1[XLEN-1];
  assign in_neg_b = signed_b(SELECT) & DATA2[XLEN-1];
  assign mag_a    = in_neg_a ? -DATA1 : DATA1;
  assign mag_b    = in_neg_b ? -DATA2 : DATA2;

  assign div_zero = (DATA2 == '0);
  assign div_ovf  = ((SELECT == F3_DIV) || (SELECT == F3_REM)) &&
                    (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
  assign fast_div = SELECT[2] && (div_zero || div_ovf);
  assign accept   = START && !FLUSH && ((state == IDLE) || (state == DONE));

  // SELECT[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    fast_val = '1;
    if (div_zero) fast_val = SELECT[1] ? DATA1 : '1;
    else          fast_val = SELECT[1] ? '0 : DATA1;
  end

  assign step_mode = op[2] ? STEP_DIV : STEP_MUL;

  alu_mdu_step #(.XLEN(XLEN)) u_step (
    .mode     (step_mode),
    .acc_in   (acc),
    .opnd     (opnd),
    .sreg_in  (sreg),
    .acc_out  (step_acc),
    .sreg_out (step_sreg)
  );

  assign prod_fix = neg_lo ? -{acc, sreg} : {acc, sreg};
  assign quot_fix = neg_lo ? -sreg : sreg;
  assign rem_fix  = neg_hi ? -acc : acc;

  always_comb begin
    fix_val = rem_fix;
    case (op)
      F3_MUL:                        fix_val = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_val = quot_fix;
      default:                       fix_val = rem_fix;
    endcase
  end

`ifdef ALU_MDU_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
  logic [XLEN-1:0]          raw_a, raw_b, fmul_val;
  logic signed [2*XLEN-1:0] ext_a, ext_b, fmul_prod;

  assign ext_a     = {{XLEN{signed_a(op) & raw_a[XLEN-1]}}, raw_a};
  assign ext_b     = {{XLEN{signed_b(op) & raw_b[XLEN-1]}}, raw_b};
  assign fmul_prod = ext_a * ext_b;
  assign fmul_val  = (op == F3_MUL) ? fmul_prod[XLEN-1:0] : fmul_prod[2*XLEN-1:XLEN];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      raw_a <= '0;
      raw_b <= '0;
    end else if (accept) begin
      raw_a <= DATA1;
      raw_b <= DATA2;
    end
  end
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (START) state_nxt = fast_div ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC: begin
        if (FAST_MUL && !op[2]) state_nxt = DONE;
        else if (cnt == '0)     state_nxt = FIX;
      end
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (FLUSH) state_nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op     <= '0;
      acc    <= '0;
      sreg   <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      RESULT <= '0;
      BUSY   <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      BUSY  <= (state_nxt == CALC) || (state_nxt == FIX);
      VALID <= (state_nxt == DONE);
      if (accept) begin
        op     <= SELECT;
        acc    <= '0;
        cnt    <= CNT_W'(XLEN - 1);
        neg_lo <= in_neg_a ^ in_neg_b;
        neg_hi <= in_neg_a;
        // Multiplier/dividend goes into the shift register, the other magnitude is the addend/divisor.
        sreg   <= SELECT[2] ? mag_a : mag_b;
        opnd   <= SELECT[2] ? mag_b : mag_a;
        if (fast_div) RESULT <= fast_val;
      end else if (!FLUSH) begin
        case (state)
          CALC: begin
            acc  <= step_acc;
            sreg <= step_sreg;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
`ifdef ALU_MDU_FAST_MUL_EN
            if (!op[2]) RESULT <= fmul_val;
`endif
          end
          FIX:     RESULT <= fix_val;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_mdu_seq: directed self-checking bench for alu_mdu_seq.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_alu_mdu_seq;

  localparam int XLEN = 32;
`ifdef ALU_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  logic            CLK = 1'b0;
  logic            RESET, START, FLUSH;
  logic [2:0]      SELECT;
  logic [XLEN-1:0] DATA1, DATA2, RESULT;
  logic            BUSY, VALID;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .FLUSH  (FLUSH),
    .BUSY   (BUSY),
    .VALID  (VALID),
    .RESULT (RESULT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Issue one op; hold START high with junk operands for 'hold' cycles after acceptance.
  // Returns in the VALID cycle so a following call is back-to-back.
  task automatic do_op(input string tag, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input int hold);
    int   lat;
    logic busy_ok;
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    tick;
    lat = 1;
    busy_ok = 1'b1;
    while (lat < 200) begin
      if (VALID) break;
      if (!BUSY) busy_ok = 1'b0;
      START = (lat <= hold);
      SELECT = 3'b000; DATA1 = 32'h5; DATA2 = 32'h7;
      tick;
      lat++;
    end
    START = 1'b0;
    if (BUSY) busy_ok = 1'b0;
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " res"}, RESULT, exp_res);
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick;
      if (VALID || BUSY) seen = 1'b1;
    end
    check({tag, " quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    SELECT = 3'b000; DATA1 = '0; DATA2 = '0;
    repeat (3) tick;
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst valid", 32'(VALID), 32'd0);
    check("rst result", RESULT, 32'h0);
    RESET = 1'b0;
    tick;

    // Iterative divide and VALID as a single pulse
    do_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    tick;
    check("valid pulse", 32'(VALID), 32'd0);
    check("result hold", RESULT, 32'hFFFF_FFFD);
    do_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);

    // Multiply family, issued back-to-back from DONE
    do_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
    do_op("mul", 3'b000, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, MUL_LAT, 0);

    // Fast-path corner cases
    do_op("divu by0", 3'b101, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("rem by0", 3'b110, 32'd123, 32'd0, 32'd123, 1, 0);
    do_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    do_op("divu noovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34, 0);
    tick;

    // START during CALC ignored; START in DONE accepted without a bubble
    do_op("divu held", 3'b101, 32'd100, 32'd7, 32'd14, 34, 10);
    do_op("div b2b", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
    tick;

    // FLUSH mid-divide
    SELECT = 3'b100; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
    tick;
    START = 1'b0;
    repeat (9) tick;
    FLUSH = 1'b1;
    tick;
    FLUSH = 1'b0;
    check("flush busy", 32'(BUSY), 32'd0);
    check("flush valid", 32'(VALID), 32'd0);
    check("flush result", RESULT, 32'hFFFF_FFF2);
    watch_no_valid("after flush", 40);

    // FLUSH and START together
    SELECT = 3'b100; DATA1 = 32'd50; DATA2 = 32'd5; START = 1'b1; FLUSH = 1'b1;
    tick;
    START = 1'b0; FLUSH = 1'b0;
    check("flush+start busy", 32'(BUSY), 32'd0);
    watch_no_valid("flush+start", 40);
    check("flush+start result", RESULT, 32'hFFFF_FFF2);

    // RESET mid-operation
    SELECT = 3'b000; DATA1 = 32'd1000; DATA2 = 32'd3; START = 1'b1;
    tick;
    START = 1'b0;
    repeat (19) tick;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    check("midrst busy", 32'(BUSY), 32'd0);
    check("midrst valid", 32'(VALID), 32'd0);
    check("midrst result", RESULT, 32'h0);
    tick;
    do_op("divu recover", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);

    // Multiply latency depends on build option; divide never does
    do_op("mul shift", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, MUL_LAT, 0);
    do_op("div build", 3'b100, 32'h1234_5678, 32'h10, 32'h0123_4567, 34, 0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised sequential multiply/divide unit for the RV32IM execute stage. It replaces the single-cycle combinational MUL/DIV/REM paths with an iterative radix-2 datapath driven by a START/BUSY/VALID handshake. The pipeline stalls on BUSY. It adds MULH, DIVU and RISC-V-defined divide-by-zero and overflow results, which the single-cycle unit does not provide.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, even)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
CLK     input   1     clock, all state updates on rising edge
RESET   input   1     synchronous, active-high reset
START   input   1     request; sampled only when BUSY=0
SELECT  input   3     M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
DATA1   input   XLEN  rs1 operand (multiplicand/dividend)
DATA2   input   XLEN  rs2 operand (multiplier/divisor)
FLUSH   input   1     abort the current operation (branch mispredict/trap)
BUSY    output  1     operation in progress; registered
VALID   output  1     one-cycle pulse, RESULT valid; registered
RESULT  output  XLEN  result; holds its value until the next VALID

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. CLK and RESET are the port names.
- Reset values: state=IDLE, BUSY=0, VALID=0, RESULT=0, counter=0, operand registers=0.
- RESET mid-operation: aborts on the next edge and returns to the reset values; no VALID is produced.
- States: IDLE, CALC, FIX, DONE.
  - BUSY=1 in CALC and FIX.
  - VALID=1 only in DONE.
- Accept rule: START=1 with state IDLE or DONE latches SELECT, DATA1 and DATA2 on that edge (edge k). START in CALC/FIX is ignored and is not queued.
- Normal path:
  - CALC occupies cycles k+1 .. k+XLEN, one radix-2 step per cycle.
  - FIX at k+XLEN+1 applies sign correction and selects the upper/lower half.
  - DONE at k+XLEN+2: VALID=1, RESULT updated.
  - Latency is XLEN+2 cycles (34 at XLEN=32).
- Multiply:
  - Operands are converted to magnitudes per signedness (MUL/MULH: both signed; MULHSU: DATA1 signed, DATA2 unsigned; MULHU: none).
  - Shift-add produces a 2*XLEN product. FIX negates the product if the signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide: restoring division on magnitudes. FIX sets the quotient sign to sign(D1)^sign(D2) and the remainder sign to sign(D1), for signed ops only.
- Fast path (bypasses CALC/FIX; DONE at k+1, latency 1):
  - DATA2=0: DIV/DIVU -> all ones; REM/REMU -> DATA1.
  - Signed overflow (DATA1=100..0, DATA2=all ones): DIV -> DATA1; REM -> 0.
- DONE exit: returns to IDLE, or to CALC/DONE if START=1 in DONE (back-to-back accepted, no bubble).
- FLUSH: in any state, the next state is IDLE with BUSY=0 and VALID=0. RESULT keeps its last value.
- FLUSH and START in the same cycle: FLUSH wins and START is dropped.
- FLUSH and RESET together: the reset values apply.
- Counter: counts XLEN-1 down to 0 in CALC. Wrap-around is impossible because the counter reloads on accept.

Optional Feature:
- ALU_MDU_FAST_MUL_EN defined:
  - MUL* ops use one registered XLEN×XLEN signed (XLEN+1)-bit multiply in CALC and skip to DONE.
  - Latency is 2 cycles.
  - Divide behaviour is unchanged.
- Undefined: all ops use the iterative path with the latencies above.

Decomposition:
- Shared package/header alu_pkg: SELECT funct3 encodings, state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3), and the default XLEN.
- One sub-module, alu_mdu_step: a combinational single radix-2 step. It takes a mode (mul/div), accumulator, operand and shift register, and returns the next accumulator/shift register. It is instantiated once and shared by multiply and divide.

Test Plan:
1. Reset, then DIV DATA1=-7 (0xFFFFFFF9), DATA2=2 -> BUSY for cycles k+1..k+33; VALID at k+34 with RESULT=0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1).
2. MULH 0x80000000 × 0x80000000 -> RESULT=0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MUL 3×-5 -> 0xFFFFFFF1.
3. DIVU 123/0 -> VALID at k+1 with RESULT=0xFFFFFFFF. REM 123/0 -> 123. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at k+1. REM on the same operands -> 0.
4. START held high during CALC with different operands -> ignored; the first result is unchanged. A new START asserted in the DONE cycle -> accepted; its VALID arrives exactly 34 cycles later.
5. FLUSH at cycle k+10 of a DIV -> BUSY=0 and no VALID; RESULT keeps its prior value. FLUSH and START in the same cycle -> nothing accepted. RESET at k+20 -> all outputs 0 the next cycle.
6. With ALU_MDU_FAST_MUL_EN defined: MUL 0x12345678×0x10 -> VALID at k+2 with RESULT=0x23456780. A DIV on the same build still has latency 34.
